// File: rtl/spi_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_wb_arbiter
//  Purpose  : Two-requester Wishbone arbiter in front of the SPI master core.
//             Requester 0 is the XIP sequencer, requester 1 is the APB
//             register path. Ownership is granted for a whole cycle (cyc)
//             tenure, so a multi-register sequence cannot be interleaved with
//             the other requester. A slave that stalls a strobe for TIMEOUT
//             cycles is abandoned through a one-cycle ABORT state that
//             signals an error to the owner.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT        stalled slave cycles tolerated before abort (1..1023)
//  Ports
//    clock          single clock, rising edge
//    reset_n        asynchronous active-low reset
//    m0_* / m1_*    requester Wishbone slave ports
//                     adr[4:0], dat_w[31:0], sel[3:0], we, stb, cyc  (in)
//                     dat_r[31:0], ack, err                          (out)
//    s_*            Wishbone master port to the SPI master core
//                     adr[4:0], dat_w[31:0], sel[3:0], we, stb, cyc  (out)
//                     dat_r[31:0], ack, err                          (in)
//    grant[1:0]     registered one-hot owner, 2'b00 when nobody owns
// ============================================================================
module spi_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,

  // requester 0 (XIP sequencer)
  input  logic [4:0]  m0_adr,
  input  logic [31:0] m0_dat_w,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_stb,
  input  logic        m0_cyc,
  output logic [31:0] m0_dat_r,
  output logic        m0_ack,
  output logic        m0_err,

  // requester 1 (APB register path)
  input  logic [4:0]  m1_adr,
  input  logic [31:0] m1_dat_w,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_stb,
  input  logic        m1_cyc,
  output logic [31:0] m1_dat_r,
  output logic        m1_ack,
  output logic        m1_err,

  // master port towards the SPI master core
  output logic [4:0]  s_adr,
  output logic [31:0] s_dat_w,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_stb,
  output logic        s_cyc,
  input  logic [31:0] s_dat_r,
  input  logic        s_ack,
  input  logic        s_err,

  output logic [1:0]  grant
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Stall threshold in the counter's own width; legal TIMEOUT values fit.
  localparam logic [9:0] C_TIMEOUT = 10'(TIMEOUT);

  state_t     r_state;
  state_t     w_state_next;

  // Requester that received the most recent grant. It also identifies the
  // owner while in ABORT, because it is updated on every grant and ABORT is
  // only ever entered straight from a grant state.
  logic       r_last_owner;
  logic       w_last_owner_next;

  logic [9:0] r_stall_cnt;
  logic [9:0] w_stall_cnt_next;

  logic [1:0] r_grant;

  // Owner's cycle and strobe, taken from the requester inputs directly so the
  // next-state logic does not depend on the output multiplexer.
  logic       w_own_cyc;
  logic       w_own_stb;
  logic       w_stalled;

  // --------------------------------------------------------------------------
  // Owner request selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    unique case (r_state)
      GNT0: begin
        w_own_cyc = m0_cyc;
        w_own_stb = m0_stb;
      end
      GNT1: begin
        w_own_cyc = m1_cyc;
        w_own_stb = m1_stb;
      end
      default: begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
      end
    endcase
  end

  // A strobe the slave has neither acknowledged nor errored this cycle.
  assign w_stalled = w_own_stb && !s_ack && !s_err;

  // --------------------------------------------------------------------------
  // State register, last owner and stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;     // requester 0 wins the first tie
      r_stall_cnt  <= '0;
      r_grant      <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
      r_stall_cnt  <= w_stall_cnt_next;
      // grant tracks the state that is being entered, so it is valid in the
      // same cycle as the state it describes.
      r_grant      <= {w_state_next == GNT1, w_state_next == GNT0};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    w_stall_cnt_next  = '0;           // cleared unless a stall continues

    unique case (r_state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          // Tie: favour whoever did not own the bus last.
          if (r_last_owner) begin
            w_state_next      = GNT0;
            w_last_owner_next = 1'b0;
          end else begin
            w_state_next      = GNT1;
            w_last_owner_next = 1'b1;
          end
        end else if (m0_cyc) begin
          w_state_next      = GNT0;
          w_last_owner_next = 1'b0;
        end else if (m1_cyc) begin
          w_state_next      = GNT1;
          w_last_owner_next = 1'b1;
        end
      end

      GNT0, GNT1: begin
        if (!w_own_cyc) begin
          // Tenure over; always pass through IDLE before the next owner.
          w_state_next = IDLE;
        end else if (w_stalled) begin
          // An ack or err in the threshold cycle keeps w_stalled low, so a
          // late response still completes normally instead of aborting.
          if (r_stall_cnt >= C_TIMEOUT) begin
            w_state_next = ABORT;
          end else begin
            w_stall_cnt_next = r_stall_cnt + 10'd1;
          end
        end
      end

      ABORT: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output multiplexer
  // --------------------------------------------------------------------------
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;

    unique case (r_state)
      GNT0: begin
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
        s_we    = m0_we;
        s_stb   = m0_stb;
        s_cyc   = m0_cyc;
        m0_ack  = s_ack;
        m0_err  = s_err;
      end
      GNT1: begin
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        s_we    = m1_we;
        s_stb   = m1_stb;
        s_cyc   = m1_cyc;
        m1_ack  = s_ack;
        m1_err  = s_err;
      end
      ABORT: begin
        // Bus is released; the abandoned owner sees a single error pulse.
        if (r_last_owner) begin
          m1_err = 1'b1;
        end else begin
          m0_err = 1'b1;
        end
      end
      default: begin
        // IDLE: bus quiet, any stray slave response is dropped.
        s_cyc = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; ack qualifies it for the owner only.
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign grant    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_spi_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_wb_arbiter
//  Purpose  : Self-checking bench for spi_wb_arbiter (TIMEOUT = 8).
//             A vector table covers arbitration, alternation, locked tenure,
//             error/ack forwarding and dropped responses; hand-written
//             sequences cover the stall abort, the ack-at-threshold race and
//             an asynchronous reset in the middle of a transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_wb_arbiter;

  localparam logic [31:0] D0 = 32'h0300_1234;
  localparam logic [31:0] D1 = 32'h0000_BEEF;

  logic        clock;
  logic        reset_n;
  logic [4:0]  m0_adr,   m1_adr;
  logic [31:0] m0_dat_w, m1_dat_w;
  logic [3:0]  m0_sel,   m1_sel;
  logic        m0_we,  m0_stb, m0_cyc;
  logic        m1_we,  m1_stb, m1_cyc;
  logic [31:0] m0_dat_r, m1_dat_r;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [4:0]  s_adr;
  logic [31:0] s_dat_w;
  logic [3:0]  s_sel;
  logic        s_we, s_stb, s_cyc;
  logic [31:0] s_dat_r;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  spi_wb_arbiter #(.TIMEOUT(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .m0_adr   (m0_adr),
    .m0_dat_w (m0_dat_w),
    .m0_sel   (m0_sel),
    .m0_we    (m0_we),
    .m0_stb   (m0_stb),
    .m0_cyc   (m0_cyc),
    .m0_dat_r (m0_dat_r),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m1_adr   (m1_adr),
    .m1_dat_w (m1_dat_w),
    .m1_sel   (m1_sel),
    .m1_we    (m1_we),
    .m1_stb   (m1_stb),
    .m1_cyc   (m1_cyc),
    .m1_dat_r (m1_dat_r),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .s_adr    (s_adr),
    .s_dat_w  (s_dat_w),
    .s_sel    (s_sel),
    .s_we     (s_we),
    .s_stb    (s_stb),
    .s_cyc    (s_cyc),
    .s_dat_r  (s_dat_r),
    .s_ack    (s_ack),
    .s_err    (s_err),
    .grant    (grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // own: which requester the s_* bus must mirror (01 m0, 10 m1, 00 none)
  // resp: expected {m0_ack, m0_err, m1_ack, m1_err}
  typedef struct {
    logic        c0, s0, we0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        c1, s1, we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        ack, err;
    logic [31:0] rd;
    logic [1:0]  gnt;
    logic [1:0]  own;
    logic [3:0]  resp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic c0, input logic s0, input logic we0,
    input logic [4:0] a0, input logic [31:0] d0,
    input logic c1, input logic s1, input logic we1,
    input logic [4:0] a1, input logic [31:0] d1,
    input logic ack, input logic err, input logic [31:0] rd,
    input logic [1:0] gnt, input logic [1:0] own, input logic [3:0] resp);
    vec_t t;
    t.c0 = c0;  t.s0 = s0;  t.we0 = we0; t.a0 = a0; t.d0 = d0;
    t.c1 = c1;  t.s1 = s1;  t.we1 = we1; t.a1 = a1; t.d1 = d1;
    t.ack = ack; t.err = err; t.rd = rd;
    t.gnt = gnt; t.own = own; t.resp = resp;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input vec_t t);
    m0_cyc = t.c0; m0_stb = t.s0; m0_we = t.we0; m0_adr = t.a0; m0_dat_w = t.d0;
    m1_cyc = t.c1; m1_stb = t.s1; m1_we = t.we1; m1_adr = t.a1; m1_dat_w = t.d1;
    s_ack  = t.ack; s_err = t.err; s_dat_r = t.rd;
  endtask

  function automatic logic [43:0] exp_bus(input vec_t t);
    case (t.own)
      2'b01:   return {t.c0, t.s0, t.we0, 4'hF, t.a0, t.d0};
      2'b10:   return {t.c1, t.s1, t.we1, 4'h3, t.a1, t.d1};
      default: return 44'd0;
    endcase
  endfunction

  task automatic all_idle();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0;
    s_ack = 0; s_err = 0; s_dat_r = '0;
  endtask

  // Watchdog: the bench is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------------------------------------------------------------
    // Vector table (one row per clock cycle, starting right after reset)
    // ---------------------------------------------------------------------
    // Tie from reset -> m0, release, m1 alone, tie again -> m0 (alternation)
    tbl.push_back(v(1,0,0,5'h04,D0, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b00,2'b00,4'b0000));
    tbl.push_back(v(1,0,0,5'h04,D0, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(0,0,0,5'h04,D0, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(0,0,0,5'h04,D0, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b00,2'b00,4'b0000));
    tbl.push_back(v(1,0,0,5'h04,D0, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b10,2'b10,4'b0000));
    tbl.push_back(v(1,0,0,5'h04,D0, 0,0,0,5'h10,D1, 0,0,32'h0, 2'b10,2'b10,4'b0000));
    tbl.push_back(v(1,0,0,5'h04,D0, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b00,2'b00,4'b0000));
    tbl.push_back(v(1,0,0,5'h04,D0, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    // Locked tenure: four m0 writes while m1_cyc stays high (one slave err)
    tbl.push_back(v(1,1,1,5'h04,32'h11111111, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(1,1,1,5'h04,32'h11111111, 1,0,0,5'h10,D1, 1,0,32'h0, 2'b01,2'b01,4'b1000));
    tbl.push_back(v(1,1,1,5'h14,32'h22222222, 1,0,0,5'h10,D1, 1,0,32'h0, 2'b01,2'b01,4'b1000));
    tbl.push_back(v(1,1,1,5'h18,32'h33333333, 1,0,0,5'h10,D1, 0,1,32'h0, 2'b01,2'b01,4'b0100));
    tbl.push_back(v(1,1,1,5'h18,32'h33333333, 1,0,0,5'h10,D1, 1,0,32'h0, 2'b01,2'b01,4'b1000));
    tbl.push_back(v(1,1,1,5'h10,32'h44444444, 1,0,0,5'h10,D1, 1,0,32'h0, 2'b01,2'b01,4'b1000));
    tbl.push_back(v(0,0,0,5'h10,32'h44444444, 1,0,0,5'h10,D1, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(0,0,0,5'h00,32'h0,        1,0,0,5'h10,D1, 0,0,32'h0, 2'b00,2'b00,4'b0000));
    // m1 read with data return, then release
    tbl.push_back(v(0,0,0,5'h00,32'h0, 1,1,0,5'h10,D1, 1,0,32'hCAFEF00D, 2'b10,2'b10,4'b0010));
    tbl.push_back(v(0,0,0,5'h00,32'h0, 0,0,0,5'h10,D1, 0,0,32'hCAFEF00D, 2'b10,2'b10,4'b0000));
    // Stray slave ack/err in IDLE is dropped
    tbl.push_back(v(0,0,0,5'h00,32'h0, 0,0,0,5'h00,32'h0, 1,1,32'h12345678, 2'b00,2'b00,4'b0000));
    // m0 write 0x03001234 to 0x04, slave acks after three wait cycles
    tbl.push_back(v(1,1,1,5'h04,D0, 0,0,0,5'h00,32'h0, 0,0,32'h0, 2'b00,2'b00,4'b0000));
    tbl.push_back(v(1,1,1,5'h04,D0, 0,0,0,5'h00,32'h0, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(1,1,1,5'h04,D0, 0,0,0,5'h00,32'h0, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(1,1,1,5'h04,D0, 0,0,0,5'h00,32'h0, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(1,1,1,5'h04,D0, 0,0,0,5'h00,32'h0, 1,0,32'h0, 2'b01,2'b01,4'b1000));
    tbl.push_back(v(0,0,0,5'h04,D0, 0,0,0,5'h00,32'h0, 0,0,32'h0, 2'b01,2'b01,4'b0000));
    tbl.push_back(v(0,0,0,5'h00,32'h0, 0,0,0,5'h00,32'h0, 0,0,32'h0, 2'b00,2'b00,4'b0000));

    // ---------------------------------------------------------------------
    // Reset state
    // ---------------------------------------------------------------------
    m0_sel = 4'hF;
    m1_sel = 4'h3;
    all_idle();
    reset_n = 1'b0;
    tick();
    tick();
    chk("reset_grant", 64'(grant), 64'(2'b00));
    chk("reset_bus",   64'({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w}), 64'd0);
    chk("reset_resp",  64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
    reset_n = 1'b1;

    // ---------------------------------------------------------------------
    // Table-driven part
    // ---------------------------------------------------------------------
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #2;
      chk($sformatf("row%0d_grant", i), 64'(grant), 64'(tbl[i].gnt));
      chk($sformatf("row%0d_bus", i),
          64'({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w}), 64'(exp_bus(tbl[i])));
      chk($sformatf("row%0d_resp", i),
          64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(tbl[i].resp));
      chk($sformatf("row%0d_datr", i), 64'({m0_dat_r, m1_dat_r}), {tbl[i].rd, tbl[i].rd});
      tick();
    end

    // ---------------------------------------------------------------------
    // Stall abort: m1 read of 0x10, slave never responds
    // ---------------------------------------------------------------------
    all_idle();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 5'h10;
    #2;
    chk("abort_req_idle", 64'(grant), 64'(2'b00));
    tick();
    for (int k = 1; k <= 9; k++) begin
      #2;
      chk($sformatf("abort_stall%0d_grant", k), 64'(grant), 64'(2'b10));
      chk($sformatf("abort_stall%0d_err", k), 64'({s_cyc, m0_err, m1_err}), 64'(3'b100));
      tick();
    end
    #2;
    chk("abort_bus",  64'({s_cyc, s_stb}), 64'(2'b00));
    chk("abort_err",  64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(4'b0001));
    chk("abort_grant", 64'(grant), 64'(2'b00));
    tick();
    #2;
    chk("post_abort_idle", 64'({grant, s_cyc, m0_err, m1_err}), 64'd0);
    tick();
    #2;
    chk("rearbitrate_grant", 64'(grant), 64'(2'b10));
    m1_cyc = 0; m1_stb = 0;
    tick();
    tick();

    // ---------------------------------------------------------------------
    // Ack arriving exactly at the threshold cycle wins over the abort
    // ---------------------------------------------------------------------
    all_idle();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 5'h14; m0_dat_w = 32'h55AA55AA;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #2;
      chk($sformatf("race_stall%0d", k), 64'({grant, m0_ack, m0_err}), 64'(4'b0100));
      tick();
    end
    s_ack = 1;
    #2;
    chk("race_ack", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(4'b1000));
    tick();
    s_ack = 0;
    #2;
    chk("race_stays_gnt0", 64'({grant, s_cyc}), 64'(3'b011));
    chk("race_no_err",     64'({m0_err, m1_err}), 64'd0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    tick();

    // ---------------------------------------------------------------------
    // Asynchronous reset in the middle of an m1 transfer
    // ---------------------------------------------------------------------
    all_idle();
    m1_cyc = 1; m1_stb = 1; m1_adr = 5'h10;
    tick();
    #2;
    chk("rst_pre_grant", 64'({grant, s_stb}), 64'(3'b101));
    m0_cyc = 1;
    s_ack  = 1;
    reset_n = 1'b0;
    #1;
    chk("rst_async_bus",   64'({s_cyc, s_stb}), 64'(2'b00));
    chk("rst_async_grant", 64'(grant), 64'(2'b00));
    chk("rst_async_resp",  64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
    tick();
    #2;
    chk("rst_held_grant", 64'({grant, s_cyc}), 64'd0);
    s_ack = 0;
    reset_n = 1'b1;
    tick();
    #2;
    chk("rst_first_tie_grant", 64'(grant), 64'(2'b01));
    chk("rst_first_tie_bus",   64'({s_cyc, s_adr}), 64'({1'b1, 5'h00}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
